ssd_capture: RTL



---
 rtl/ssd_capture_if.sv | 11 +
 rtl/ssd_capture.sv | 112 +++++++++++
 2 files changed

// File: rtl/ssd_capture_if.sv
// ssd_capture_if: scanned seven-segment bus in, captured BCD frame out.
interface ssd_capture_if;
   logic [7:0]  ssd;
   logic [3:0]  ssd_ctl;
   logic [15:0] bcd_out;
   logic [3:0]  dp_out;
   logic        frame_done;
   logic        err;
   modport master (output ssd, ssd_ctl, input bcd_out, dp_out, frame_done, err);
   modport slave  (input ssd, ssd_ctl, output bcd_out, dp_out, frame_done, err);
endinterface

// File: rtl/ssd_capture.sv
// ssd_capture: debounces a scanned 4-digit active-low 7-seg bus back into a BCD frame.
// Define SSD_CAPTURE_DP_EN to also capture decimal points into dp_out.
module ssd_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   ssd_capture_if.slave bus
);
   localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b0000001: return 5'h00;
         7'b1001111: return 5'h01;
         7'b0010010: return 5'h02;
         7'b0000110: return 5'h03;
         7'b1001100: return 5'h04;
         7'b0100100: return 5'h05;
         7'b0100000: return 5'h06;
         7'b0001111: return 5'h07;
         7'b0000000: return 5'h08;
         7'b0000100: return 5'h09;
         7'b0111000: return 5'h0f;
         default:    return 5'h1e;
      endcase
   endfunction

   logic [11:0]   sample_r;
   logic [CW-1:0] cnt;
   logic          armed;
   logic [3:0]    mask;
   logic [15:0]   shadow;
   logic [3:0]    sel_n;
   logic          sel_ok;
   logic [1:0]    sel;
   logic          changed;
   logic          stable;
   logic          accept;
   logic [3:0]    dig;
   logic          bad;
   logic [3:0]    mask_nx;
   logic [15:0]   shadow_nx;

   always_comb begin
      sel_n     = ~sample_r[11:8];
      sel_ok    = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);
      sel       = sel_n[1] ? 2'd1 : sel_n[2] ? 2'd2 : sel_n[3] ? 2'd3 : 2'd0;
      changed   = {bus.ssd_ctl, bus.ssd} != sample_r;
      // the incoming sample must still match, so a pattern held only STABLE_CYCLES is rejected
      stable    = sel_ok && !changed;
      accept    = stable && armed && (cnt == CMAX);
      {bad, dig} = decode(sample_r[7:1]);
      mask_nx   = mask | (4'd1 << sel);
      shadow_nx = shadow;
      shadow_nx[sel*4 +: 4] = dig;
   end

`ifdef SSD_CAPTURE_DP_EN
   logic [3:0] dp_sh;
   logic [3:0] dp_nx;
   always_comb begin
      dp_nx      = dp_sh;
      dp_nx[sel] = ~sample_r[0];
   end
`else
   assign bus.dp_out = 4'b0000;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_r       <= '0;
         cnt            <= '0;
         armed          <= 1'b1;
         mask           <= '0;
         shadow         <= '0;
         bus.bcd_out    <= '0;
         bus.frame_done <= 1'b0;
         bus.err        <= 1'b0;
`ifdef SSD_CAPTURE_DP_EN
         dp_sh          <= '0;
         bus.dp_out     <= '0;
`endif
      end else begin
         sample_r       <= {bus.ssd_ctl, bus.ssd};
         cnt            <= stable ? ((cnt == CMAX) ? cnt : cnt + 1'b1) : '0;
         bus.frame_done <= 1'b0;
         bus.err        <= 1'b0;
         if (accept) begin
            armed   <= 1'b0;
            shadow  <= shadow_nx;
            bus.err <= bad;
`ifdef SSD_CAPTURE_DP_EN
            dp_sh   <= dp_nx;
`endif
            if (mask_nx == 4'hf) begin
               mask           <= '0;
               bus.bcd_out    <= shadow_nx;
               bus.frame_done <= 1'b1;
`ifdef SSD_CAPTURE_DP_EN
               bus.dp_out     <= dp_nx;
`endif
            end else begin
               mask <= mask_nx;
            end
         end else if (changed) begin
            armed <= 1'b1;
         end
      end
   end
endmodule
